// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: freeze/flush/load-use resolution,
// EX operand forwarding, saturating event counters and a freeze watchdog.
module pipe_hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int FREEZE_MAX = 64
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic [4:0]       ex_rn,
  input  logic [4:0]       ex_rm,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_pcsrc,
  input  logic             mem_busy,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic             freeze_timeout
);

  localparam int RUN_W = $clog2(FREEZE_MAX + 1);
  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic {ST_RUN = 1'b0, ST_FREEZE = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RUN_W-1:0] r_run;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_freeze_cnt;
  logic             r_timeout;
  logic             w_load_use;
  logic             w_do_flush;
  logic             w_do_stall;

  // MEM holds the younger producer, so it wins over WB; XZR is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] m_rd,
                                         input logic m_rw, input logic [4:0] w_rd,
                                         input logic w_rw);
    logic [1:0] sel;
    sel = 2'b00;
    if (m_rw && (m_rd != XZR) && (m_rd == src)) begin
      sel = 2'b10;
    end else if (w_rw && (w_rd != XZR) && (w_rd == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign w_load_use = ex_memread && (ex_rd != XZR) &&
                      ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));
  assign w_do_flush = !mem_busy && mem_pcsrc;
  assign w_do_stall = !mem_busy && !mem_pcsrc && w_load_use;

  // Priority resolution of enables/flushes plus forwarding; reset forces bubbles.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    fwd_a       = fwd_sel(ex_rn, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    fwd_b       = fwd_sel(ex_rm, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    if (!resetl) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
      fwd_a = 2'b00;
      fwd_b = 2'b00;
    end else if (mem_busy) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
    end else if (mem_pcsrc) begin
      {ifid_flush, idex_flush, exmem_flush} = 3'b111;
    end else if (w_load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

  // Next-state logic for the RUN/FREEZE observer FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    w_state_nxt = mem_busy ? ST_FREEZE : ST_RUN;
      ST_FREEZE: w_state_nxt = mem_busy ? ST_FREEZE : ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // State register, event counters and freeze watchdog.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_state      <= ST_RUN;
      r_run        <= {RUN_W{1'b0}};
      r_stall_cnt  <= {CNT_W{1'b0}};
      r_flush_cnt  <= {CNT_W{1'b0}};
      r_freeze_cnt <= {CNT_W{1'b0}};
      r_timeout    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (mem_busy) begin
        r_freeze_cnt <= sat_inc(r_freeze_cnt);
        if (r_run != RUN_W'(FREEZE_MAX)) begin
          r_run <= r_run + {{(RUN_W-1){1'b0}}, 1'b1};
        end
        if (r_run == RUN_W'(FREEZE_MAX - 1)) begin
          r_timeout <= 1'b1;
        end
      end else begin
        r_run <= {RUN_W{1'b0}};
      end
      if (w_do_flush) begin
        r_flush_cnt <= sat_inc(r_flush_cnt);
      end
      if (w_do_stall) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
    end
  end

  assign ctrl_state     = r_state;
  assign stall_cnt      = r_stall_cnt;
  assign flush_cnt      = r_flush_cnt;
  assign freeze_cnt     = r_freeze_cnt;
  assign freeze_timeout = r_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        resetl;
  logic [4:0]  id_rn, id_rm, ex_rn, ex_rm, ex_rd, mem_rd, wb_rd;
  logic        id_uses_rn, id_uses_rm, ex_memread, mem_regwrite, mem_pcsrc, mem_busy, wb_regwrite;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        ctrl_state, freeze_timeout;
  logic [15:0] stall_cnt, flush_cnt, freeze_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(16), .FREEZE_MAX(4)) dut (
    .clk(clk), .resetl(resetl),
    .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_pcsrc(mem_pcsrc), .mem_busy(mem_busy),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .ctrl_state(ctrl_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt),
    .freeze_timeout(freeze_timeout)
  );

  typedef struct {
    string      name;
    logic [4:0] id_rn, id_rm;
    logic       uses_rn, uses_rm;
    logic [4:0] ex_rn, ex_rm, ex_rd;
    logic       memread;
    logic [4:0] mem_rd;
    logic       mem_rw, pcsrc, busy;
    logic [4:0] wb_rd;
    logic       wb_rw;
    logic [4:0] exp_en;   // {pc, ifid, idex, exmem, memwb}
    logic [2:0] exp_fl;   // {ifid, idex, exmem}
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_rn = 5'd0; id_rm = 5'd0; id_uses_rn = 1'b0; id_uses_rm = 1'b0;
    ex_rn = 5'd0; ex_rm = 5'd0; ex_rd = 5'd0; ex_memread = 1'b0;
    mem_rd = 5'd0; mem_regwrite = 1'b0; mem_pcsrc = 1'b0; mem_busy = 1'b0;
    wb_rd = 5'd0; wb_regwrite = 1'b0;
  endtask

  task automatic chk_comb(input string name, input logic [4:0] en, input logic [2:0] fl);
    chk({name, " en"}, {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, en});
    chk({name, " fl"}, {29'd0, ifid_flush, idex_flush, exmem_flush}, {29'd0, fl});
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetl = 1'b0;
    idle();
    #1;
    chk("rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("rst freeze_cnt", {16'd0, freeze_cnt}, 32'd0);
    chk("rst state", {31'd0, ctrl_state}, 32'd0);
    chk("rst timeout", {31'd0, freeze_timeout}, 32'd0);
    chk_comb("rst", 5'b00000, 3'b111);
    @(negedge clk);
    resetl = 1'b1;
  endtask

  initial begin
    //          name         idrn  idrm  urn   urm   exrn  exrm  exrd  mrd   memrd mrw   pcs   busy  wbrd  wbrw  en        fl      fa     fb
    vecs[0]  = '{"idle",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b11111, 3'b000, 2'b00, 2'b00};
    vecs[1]  = '{"lu_rn",    5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00111, 3'b010, 2'b00, 2'b00};
    vecs[2]  = '{"lu_rm",    5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00111, 3'b010, 2'b00, 2'b00};
    vecs[3]  = '{"lu_unused",5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b11111, 3'b000, 2'b00, 2'b00};
    vecs[4]  = '{"lu_xzr",   5'd31,5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd31,1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b11111, 3'b000, 2'b00, 2'b00};
    vecs[5]  = '{"flush_lu", 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'b11111, 3'b111, 2'b00, 2'b00};
    vecs[6]  = '{"freeze_br",5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'b00000, 3'b000, 2'b00, 2'b00};
    vecs[7]  = '{"fwd_prio", 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 5'b11111, 3'b000, 2'b10, 2'b00};
    vecs[8]  = '{"fwd_wb_b", 5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd4, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 5'b11111, 3'b000, 2'b00, 2'b01};
    vecs[9]  = '{"fwd_xzr",  5'd0, 5'd0, 1'b0, 1'b0, 5'd31,5'd31,5'd0, 1'b0, 5'd31,1'b1, 1'b0, 1'b0, 5'd31,1'b1, 5'b11111, 3'b000, 2'b00, 2'b00};
    vecs[10] = '{"fwd_frz",  5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 5'd0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'b00000, 3'b000, 2'b10, 2'b00};
    vecs[11] = '{"fwd_norw", 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 5'd6, 5'd0, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1, 5'b11111, 3'b000, 2'b01, 2'b01};

    resetl = 1'b0;
    idle();
    do_reset();

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      id_rn = vecs[i].id_rn; id_rm = vecs[i].id_rm;
      id_uses_rn = vecs[i].uses_rn; id_uses_rm = vecs[i].uses_rm;
      ex_rn = vecs[i].ex_rn; ex_rm = vecs[i].ex_rm; ex_rd = vecs[i].ex_rd;
      ex_memread = vecs[i].memread; mem_rd = vecs[i].mem_rd; mem_regwrite = vecs[i].mem_rw;
      mem_pcsrc = vecs[i].pcsrc; mem_busy = vecs[i].busy;
      wb_rd = vecs[i].wb_rd; wb_regwrite = vecs[i].wb_rw;
      #1;
      chk_comb(vecs[i].name, vecs[i].exp_en, vecs[i].exp_fl);
      chk({vecs[i].name, " fwd_a"}, {30'd0, fwd_a}, {30'd0, vecs[i].exp_fa});
      chk({vecs[i].name, " fwd_b"}, {30'd0, fwd_b}, {30'd0, vecs[i].exp_fb});
    end

    // Load-use bubble then WB forwarding to the dependent instruction.
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rn = 5'd5; id_uses_rn = 1'b1;
    #1;
    chk_comb("lu_seq", 5'b00111, 3'b010);
    edge_step();
    chk("lu stall_cnt", {16'd0, stall_cnt}, 32'd1);
    @(negedge clk);
    idle();
    ex_rn = 5'd5; wb_rd = 5'd5; wb_regwrite = 1'b1;
    #1;
    chk("lu fwd_a", {30'd0, fwd_a}, 32'd1);
    chk_comb("lu_after", 5'b11111, 3'b000);
    edge_step();
    chk("lu stall_cnt hold", {16'd0, stall_cnt}, 32'd1);

    // Flush wins over a simultaneous load-use.
    @(negedge clk);
    idle();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rn = 5'd5; id_uses_rn = 1'b1; mem_pcsrc = 1'b1;
    edge_step();
    chk("fl flush_cnt", {16'd0, flush_cnt}, 32'd1);
    chk("fl stall_cnt", {16'd0, stall_cnt}, 32'd1);

    // Freeze three cycles with a pending branch, then the deferred flush.
    @(negedge clk);
    idle();
    mem_busy = 1'b1; mem_pcsrc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      chk("frz state", {31'd0, ctrl_state}, 32'd1);
      chk_comb("frz", 5'b00000, 3'b000);
    end
    chk("frz freeze_cnt", {16'd0, freeze_cnt}, 32'd3);
    chk("frz flush_cnt", {16'd0, flush_cnt}, 32'd1);
    chk("frz timeout", {31'd0, freeze_timeout}, 32'd0);
    @(negedge clk);
    mem_busy = 1'b0;
    #1;
    chk_comb("frz_release", 5'b11111, 3'b111);
    edge_step();
    chk("rel state", {31'd0, ctrl_state}, 32'd0);
    chk("rel flush_cnt", {16'd0, flush_cnt}, 32'd2);
    @(negedge clk);
    mem_pcsrc = 1'b0;

    // Watchdog trips on the 4th consecutive busy edge and stays set.
    mem_busy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      edge_step();
      chk($sformatf("wd edge%0d", i), {31'd0, freeze_timeout}, (i == 4) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    mem_busy = 1'b0;
    edge_step();
    chk("wd sticky", {31'd0, freeze_timeout}, 32'd1);
    chk("wd freeze_cnt", {16'd0, freeze_cnt}, 32'd7);

    // Asynchronous reset between edges while frozen.
    @(negedge clk);
    mem_busy = 1'b1; ex_rn = 5'd3; mem_rd = 5'd3; mem_regwrite = 1'b1;
    edge_step();
    #2;
    resetl = 1'b0;
    #1;
    chk("ar state", {31'd0, ctrl_state}, 32'd0);
    chk("ar freeze_cnt", {16'd0, freeze_cnt}, 32'd0);
    chk("ar flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("ar timeout", {31'd0, freeze_timeout}, 32'd0);
    chk("ar fwd_a", {30'd0, fwd_a}, 32'd0);
    chk_comb("ar", 5'b00000, 3'b111);
    @(negedge clk);
    idle();
    resetl = 1'b1;
    #1;
    chk_comb("ar_release", 5'b11111, 3'b000);
    edge_step();
    chk("ar post state", {31'd0, ctrl_state}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
